corner_detector: RTL

- Producer side of the packed corner-load interface: scans one thresholded video frame and finds the four extreme corners of the bright region (the projected screen/page).
- Delivers the result as an 80-bit packed word plus a one-cycle load strobe. The manual corner-adjust block consumes both and then lets the user nudge the corners.
- Sits between the pixel threshold stage and corner adjust; one capture per request.

---
 rtl/corner_detector.sv | 120 ++++++++++++
 1 files changed

// File: rtl/corner_detector.sv
// Scans one thresholded frame per capture request and publishes the four extreme
// corners of the bright region as a packed word with a one-cycle load strobe.
module corner_detector #(
   parameter int MIN_PIXELS = 64,
   parameter int CNT_W      = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        capture_req,
   input  logic        frame_start,
   input  logic        frame_end,
   input  logic        pixel_valid,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        pixel_bright,
   output logic [79:0] auto_corners,
   output logic        set_corners,
   output logic        corners_found,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

   // Corners 2 (top-right) and 3 (bottom-right) track maxima, 1 and 4 track minima.
   localparam logic [3:0]       MAX_MASK = 4'b0110;
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              first_q;
   logic [3:0][10:0]  best_q;
   logic [3:0][9:0]   cx_q;
   logic [3:0][9:0]   cy_q;
   logic [79:0]       auto_q;
   logic              set_q;
   logic              found_q;

   logic [10:0]       s_metric;
   logic [10:0]       d_metric;
   logic [3:0][10:0]  metric;
   logic [3:0]        better;
   logic              init;
   logic              qual;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture_req) state_d = ARMED;
         ARMED:   if (frame_start) state_d = SCAN;
         SCAN:    if (frame_end)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // x + 1023 never exceeds 2046, so subtracting y afterwards cannot wrap.
   assign s_metric = {1'b0, pixel_x} + {1'b0, pixel_y};
   assign d_metric = ({1'b0, pixel_x} + 11'd1023) - {1'b0, pixel_y};

   assign init = frame_start && ((state_q == ARMED) || ((state_q == SCAN) && !frame_end));
   assign qual = (state_q == SCAN) && pixel_valid && pixel_bright && !frame_end;

   for (genvar gi = 0; gi < 4; gi++) begin : g_corner
      assign metric[gi] = ((gi % 2) == 1) ? d_metric : s_metric;
      assign better[gi] = MAX_MASK[gi] ? (metric[gi] > best_q[gi])
                                       : (metric[gi] < best_q[gi]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         first_q <= 1'b0;
         best_q  <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         auto_q  <= '0;
         set_q   <= 1'b0;
         found_q <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= 1'b0;
         if (init) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
            for (int i = 0; i < 4; i++) begin
               best_q[i] <= MAX_MASK[i] ? 11'd0 : 11'd2047;
            end
         end else if (qual) begin
            first_q <= 1'b0;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            // Strict compare keeps the earliest pixel in raster order on ties.
            for (int i = 0; i < 4; i++) begin
               if (first_q || better[i]) begin
                  best_q[i] <= metric[i];
                  cx_q[i]   <= pixel_x;
                  cy_q[i]   <= pixel_y;
               end
            end
         end
         if ((state_q == SCAN) && frame_end) begin
            if (cnt_q >= MIN_CNT) begin
               auto_q  <= {cx_q[0], cy_q[0], cx_q[1], cy_q[1],
                           cx_q[2], cy_q[2], cx_q[3], cy_q[3]};
               found_q <= 1'b1;
               set_q   <= 1'b1;
            end else begin
               found_q <= 1'b0;
            end
         end
      end
   end

   assign auto_corners  = auto_q;
   assign set_corners   = set_q;
   assign corners_found = found_q;
   assign busy          = (state_q == ARMED) || (state_q == SCAN);

endmodule
